// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one W-bit ALU between two requesters: port 0 is the execute stage
//   and port 1 is the address/branch-compare unit. Requests are granted
//   round-robin. The winner's operands and selector are registered and drive
//   the ALU. The ALU result and Z flag are registered and then returned on
//   a per-port response handshake.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid / reqN_ready       request handshake, port N (0 or 1)
//   reqN_a, reqN_b, reqN_sel      operands and ALU op of port N
//   respN_valid / respN_ready     response handshake, port N
//   resp_o, resp_z                registered result and Z flag (shared)
//   alu_a, alu_b, alu_sel         registered ALU inputs
//   alu_o, alu_z                  combinational ALU result and Z flag
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | arbitrate; winner's ready is high, operands captured on transfer
// EXEC  | ALU driven from operand registers; result captured at edge
// RESP  | respN_valid high for granted port until its respN_ready

module alu_arbiter #(
    parameter int W       = 32,
    parameter bit RR_INIT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [2:0]   req0_sel,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [2:0]   req1_sel,

    output logic         resp0_valid,
    input  logic         resp0_ready,
    output logic         resp1_valid,
    input  logic         resp1_ready,
    output logic [W-1:0] resp_o,
    output logic         resp_z,

    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_sel,
    input  logic [W-1:0] alu_o,
    input  logic         alu_z
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           ptr_q,   ptr_d;
    logic           gnt_q,   gnt_d;
    logic [W-1:0]   a_q,     a_d;
    logic [W-1:0]   b_q,     b_d;
    logic [2:0]     sel_q,   sel_d;
    logic [W-1:0]   res_q,   res_d;
    logic           z_q,     z_d;

    logic           any_valid;
    logic           win;
    logic           xfer;
    logic           resp_take;

    // Winner index: a lone requester always wins; under contention the
    // pointer decides.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        win       = (req0_valid & req1_valid) ? ptr_q : req1_valid;
        xfer      = (state_q == S_IDLE) & any_valid;
        resp_take = gnt_q ? resp1_ready : resp0_ready;
    end

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= RR_INIT;
            gnt_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 3'b111;
            res_q   <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            res_q   <= res_d;
            z_q     <= z_d;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        res_d   = res_q;
        z_d     = z_q;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    state_d = S_EXEC;
                    gnt_d   = win;
                    // Favour the loser next time, even after an uncontended grant.
                    ptr_d   = ~win;
                    a_d     = win ? req1_a   : req0_a;
                    b_d     = win ? req1_b   : req0_b;
                    sel_d   = win ? req1_sel : req0_sel;
                end
            end
            S_EXEC: begin
                state_d = S_RESP;
                res_d   = alu_o;
                z_d     = alu_z;
            end
            S_RESP: begin
                if (resp_take) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        if (state_q == S_IDLE) begin
            req0_ready = any_valid & ~win;
            req1_ready = any_valid &  win;
        end
        if (state_q == S_RESP) begin
            resp0_valid = ~gnt_q;
            resp1_valid =  gnt_q;
        end
    end

    assign resp_o  = res_q;
    assign resp_z  = z_q;
    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign alu_sel = sel_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_sel, req1_sel;
    logic         resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [W-1:0] resp_o;
    logic         resp_z;
    logic [W-1:0] alu_a, alu_b, alu_o;
    logic [2:0]   alu_sel;
    logic         alu_z;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.W(W), .RR_INIT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_o(resp_o), .resp_z(resp_z),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_o(alu_o), .alu_z(alu_z)
    );

    // Operation semantics of the shared ALU
    function automatic logic [31:0] alu_fn(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
        case (s)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a ^ b;
            3'd3: return a & b;
            3'd4: return a << b[4:0];
            3'd5: return a >> b[4:0];
            3'd6: return 32'($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    assign alu_o = alu_fn(alu_sel, alu_a, alu_b);
    assign alu_z = (alu_o != 32'd0);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'd1; req0_b = 32'd2; req0_sel = 3'd0;
        req1_a = 32'd3; req1_b = 32'd4; req1_sel = 3'd0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        smp();
        n_cmp++; if (resp_o !== 32'd0) begin n_bad++; $display("FAIL reset_resp_o: got %h exp 0", resp_o); end
        n_cmp++; if (resp_z !== 1'b0) begin n_bad++; $display("FAIL reset_resp_z: got %b exp 0", resp_z); end
        n_cmp++; if (alu_sel !== 3'b111) begin n_bad++; $display("FAIL reset_alu_sel: got %b exp 111", alu_sel); end
        n_cmp++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin n_bad++; $display("FAIL reset_alu_ab: got %h %h exp 0 0", alu_a, alu_b); end
        n_cmp++; if ({resp0_valid, resp1_valid} !== 2'b00) begin n_bad++; $display("FAIL reset_resp_valid: got %b exp 00", {resp0_valid, resp1_valid}); end
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL reset_ready: got %b exp 10", {req0_ready, req1_ready}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_single_add();
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_sel = 3'd0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        smp();
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL add_ready: got %b exp 10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 1'b0; req0_a = $urandom; req0_b = $urandom; req0_sel = 3'd3;
        smp();
        n_cmp++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_sel !== 3'd0) begin n_bad++; $display("FAIL add_alu_in: got %h %h %b exp 5 7 000", alu_a, alu_b, alu_sel); end
        n_cmp++; if ({resp0_valid, resp1_valid} !== 2'b00) begin n_bad++; $display("FAIL add_exec_valid: got %b exp 00", {resp0_valid, resp1_valid}); end
        tick();
        smp();
        n_cmp++; if ({resp0_valid, resp1_valid} !== 2'b10) begin n_bad++; $display("FAIL add_resp_valid: got %b exp 10", {resp0_valid, resp1_valid}); end
        n_cmp++; if (resp_o !== 32'd12 || resp_z !== 1'b1) begin n_bad++; $display("FAIL add_result: got %h z%b exp 0000000c z1", resp_o, resp_z); end
        tick();
        smp();
        n_cmp++; if ({resp0_valid, resp1_valid} !== 2'b00) begin n_bad++; $display("FAIL add_resp_drop: got %b exp 00", {resp0_valid, resp1_valid}); end
        tick();
    endtask

    task automatic test_contention();
        logic [31:0] exp_o;
        logic        exp_z;
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd10; req0_sel = 3'd1;
        req1_valid = 1'b1; req1_a = 32'h8000_0000; req1_b = 32'd4; req1_sel = 3'd6;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_o = (k % 2 == 0) ? 32'd0 : 32'hF800_0000;
            exp_z = (k % 2 != 0);
            smp();
            n_cmp++; if ({req0_ready, req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL cont_grant%0d: got %b", k, {req0_ready, req1_ready}); end
            tick();
            smp();
            n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL cont_exec_ready%0d: got %b exp 00", k, {req0_ready, req1_ready}); end
            tick();
            smp();
            n_cmp++; if ({resp0_valid, resp1_valid} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL cont_resp_valid%0d: got %b", k, {resp0_valid, resp1_valid}); end
            n_cmp++; if (resp_o !== exp_o || resp_z !== exp_z) begin n_bad++; $display("FAIL cont_result%0d: got %h z%b exp %h z%b", k, resp_o, resp_z, exp_o, exp_z); end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        req1_valid = 1'b1; req1_a = 32'hFF; req1_b = 32'h0F; req1_sel = 3'd2;
        resp1_ready = 1'b0; resp0_ready = 1'b1;
        smp();
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b01) begin n_bad++; $display("FAIL bp_grant: got %b exp 01", {req0_ready, req1_ready}); end
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_sel = 3'd0;
        smp();
        n_cmp++; if (req0_ready !== 1'b0) begin n_bad++; $display("FAIL bp_exec_ready0: got %b exp 0", req0_ready); end
        tick();
        for (int i = 0; i < 5; i++) begin
            smp();
            n_cmp++; if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0) begin n_bad++; $display("FAIL bp_hold_valid%0d: got %b%b exp 01", i, resp0_valid, resp1_valid); end
            n_cmp++; if (resp_o !== 32'hF0 || resp_z !== 1'b1) begin n_bad++; $display("FAIL bp_hold_data%0d: got %h z%b exp f0 z1", i, resp_o, resp_z); end
            n_cmp++; if (req0_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold_ready0_%0d: got %b exp 0", i, req0_ready); end
            tick();
        end
        resp1_ready = 1'b1;
        smp();
        n_cmp++; if (resp1_valid !== 1'b1 || req0_ready !== 1'b0) begin n_bad++; $display("FAIL bp_release: got valid1 %b ready0 %b exp 1 0", resp1_valid, req0_ready); end
        tick();
        smp();
        n_cmp++; if (resp1_valid !== 1'b0 || req0_ready !== 1'b1) begin n_bad++; $display("FAIL bp_next_grant: got valid1 %b ready0 %b exp 0 1", resp1_valid, req0_ready); end
        tick();
        req0_valid = 1'b0;
        tick();
        smp();
        n_cmp++; if (resp0_valid !== 1'b1 || resp_o !== 32'd3) begin n_bad++; $display("FAIL bp_port0_result: got v%b %h exp v1 3", resp0_valid, resp_o); end
        tick();
    endtask

    task automatic test_reset_exec();
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd31; req0_sel = 3'd4;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        smp();
        n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL rexec_grant: got %b exp 1", req0_ready); end
        tick();
        req0_valid = 1'b0; rst = 1'b1;
        smp();
        n_cmp++; if (alu_sel !== 3'd4 || alu_a !== 32'd1) begin n_bad++; $display("FAIL rexec_alu_in: got %b %h exp 100 1", alu_sel, alu_a); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            n_cmp++; if ({resp0_valid, resp1_valid} !== 2'b00 || resp_o !== 32'd0) begin n_bad++; $display("FAIL rexec_no_resp%0d: got %b%b %h exp 00 0", i, resp0_valid, resp1_valid, resp_o); end
            tick();
        end
        n_cmp++; if (alu_sel !== 3'b111) begin n_bad++; $display("FAIL rexec_alu_sel: got %b exp 111", alu_sel); end
        req0_valid = 1'b1; req1_valid = 1'b1;
        smp();
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL rexec_ptr_reload: got %b exp 10", {req0_ready, req1_ready}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_invalid_sel();
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_sel = 3'd0;
        tick();
        req1_valid = 1'b0;
        tick();
        smp();
        n_cmp++; if (resp1_valid !== 1'b1 || resp_o !== 32'd2) begin n_bad++; $display("FAIL inv_pre: got v%b %h exp v1 2", resp1_valid, resp_o); end
        tick();
        req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_sel = 3'b111;
        smp();
        n_cmp++; if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL inv_grant: got %b exp 1", req1_ready); end
        tick();
        req1_valid = 1'b0;
        smp();
        n_cmp++; if (alu_sel !== 3'b111 || alu_a !== 32'd3 || alu_b !== 32'd4) begin n_bad++; $display("FAIL inv_alu_in: got %b %h %h exp 111 3 4", alu_sel, alu_a, alu_b); end
        tick();
        smp();
        n_cmp++; if (resp1_valid !== 1'b1 || resp_o !== 32'd0 || resp_z !== 1'b0) begin n_bad++; $display("FAIL inv_result: got v%b %h z%b exp v1 0 z0", resp1_valid, resp_o, resp_z); end
        tick();
    endtask

    // Random traffic against a transaction-level model: a single slot that
    // is free or holds one operation, a pointer naming the favoured port,
    // and results computed straight from the operation semantics.
    task automatic test_random_traffic();
        logic        m_ptr, m_busy, m_port, w, exp_v0, exp_v1, was_busy, take;
        logic [31:0] m_res;
        int          m_start;
        do_reset();
        m_ptr = 1'b0; m_busy = 1'b0; m_port = 1'b0; m_res = '0; m_start = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_a = $urandom; req0_b = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 31));
            req1_a = $urandom; req1_b = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 31));
            req0_sel = 3'($urandom_range(0, 7));
            req1_sel = 3'($urandom_range(0, 7));
            if (($urandom_range(0, 3)) == 0) req1_a = req1_b;
            resp0_ready = ($urandom_range(0, 4) < 3);
            resp1_ready = ($urandom_range(0, 4) < 3);
            smp();
            w = (req0_valid && req1_valid) ? m_ptr : req1_valid;
            n_cmp++;
            if (!m_busy && (req0_valid || req1_valid)) begin
                if ({req0_ready, req1_ready} !== (w ? 2'b01 : 2'b10)) begin n_bad++; $display("FAIL rnd_ready c%0d: got %b%b exp port %0d", cyc, req0_ready, req1_ready, w); end
            end else begin
                if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL rnd_ready c%0d: got %b%b exp 00", cyc, req0_ready, req1_ready); end
            end
            exp_v0 = m_busy && (cyc >= m_start + 2) && (m_port == 1'b0);
            exp_v1 = m_busy && (cyc >= m_start + 2) && (m_port == 1'b1);
            n_cmp++; if ({resp0_valid, resp1_valid} !== {exp_v0, exp_v1}) begin n_bad++; $display("FAIL rnd_resp_valid c%0d: got %b%b exp %b%b", cyc, resp0_valid, resp1_valid, exp_v0, exp_v1); end
            if (exp_v0 || exp_v1) begin
                n_cmp++; if (resp_o !== m_res || resp_z !== (m_res != 32'd0)) begin n_bad++; $display("FAIL rnd_result c%0d: got %h z%b exp %h z%b", cyc, resp_o, resp_z, m_res, (m_res != 32'd0)); end
            end
            was_busy = m_busy;
            take = m_port ? resp1_ready : resp0_ready;
            if (was_busy) begin
                if ((exp_v0 || exp_v1) && take) m_busy = 1'b0;
            end else if (req0_valid || req1_valid) begin
                m_busy  = 1'b1;
                m_start = cyc;
                m_port  = w;
                m_res   = w ? alu_fn(req1_sel, req1_a, req1_b) : alu_fn(req0_sel, req0_a, req0_b);
                m_ptr   = ~w;
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_contention();
        test_backpressure();
        test_reset_exec();
        test_invalid_sel();
        test_random_traffic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 32-bit ALU datapath between two requesters:
- port 0, the execute stage;
- port 1, the address/branch-compare unit.

Each requester hands over an operation with a valid/ready handshake. The block grants one requester round-robin, registers its operands and selector, drives the ALU, captures O and Z, and returns them on a per-port response handshake. It sits between the control unit and the ALU; the ALU itself is unchanged.

## Interface
- W, 32, datapath width; must equal the ALU width.
- RR_INIT, 0, requester favoured first after reset (0 or 1).

- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester has an operation pending.
- req0_ready / req1_ready  out  1  operation accepted this cycle (valid & ready = transfer).
- req0_a, req0_b / req1_a, req1_b  in  W  operands.
- req0_sel / req1_sel  in  3  ALU op: 000 ADD, 001 SUB, 010 XOR, 011 AND, 100 SLLI, 101 SRLI, 110 SRAI.
- resp0_valid / resp1_valid  out  1  result available for that port.
- resp0_ready / resp1_ready  in  1  port consumes its result.
- resp_o  out  W  registered ALU result; shared by both ports.
- resp_z  out  1  registered ALU Z flag (1 = result non-zero).
- alu_a, alu_b  out  W  ALU operands, from internal registers.
- alu_sel  out  3  ALU selector, from internal register.
- alu_o  in  W  ALU result (combinational).
- alu_z  in  1  ALU flag (combinational).

## Operation
- State machine: IDLE → EXEC → RESP → IDLE. Encoding is free.
- **IDLE**
  - Winner: if only one reqN_valid is set, that port wins. If both are set, the port named by the priority pointer wins.
  - Only the winner's reqN_ready is high. It is combinational, high only in IDLE, and never high for both ports.
  - On transfer: capture a, b and sel into the operand registers, record the grant index, flip the pointer to the other port, go to EXEC.
  - No valid: stay in IDLE. Pointer and registers are unchanged.
- **EXEC**
  - alu_a, alu_b and alu_sel are driven from the registers.
  - At the clock edge: capture resp_o ← alu_o and resp_z ← alu_z, go to RESP.
- **RESP**
  - respN_valid is high for the granted port only; resp_o and resp_z are stable.
  - Stay in RESP while respN_ready is low (backpressure).
  - When respN_ready is high: go to IDLE.
  - The other port's respN_ready is ignored.
- **Selector 111:** passed through unchanged. The ALU returns 0, so resp_z = 0.
- **Operand registers:** hold their value outside EXEC; there is no per-cycle toggling of ALU inputs.
- **Pointer flip:** on every accepted request, including an uncontended one. After an uncontended grant to port 0, port 1 is favoured at the next contention.
- **Input changes:** a requester may change a, b or sel while its ready is low; the block samples only on transfer.

## Timing
- **Reset values:**
  - state IDLE;
  - req0_ready and req1_ready follow IDLE arbitration (combinational on valid);
  - resp0_valid, resp1_valid = 0;
  - resp_o = 0, resp_z = 0;
  - alu_a = 0, alu_b = 0, alu_sel = 3'b111;
  - pointer = RR_INIT;
  - grant index = 0.
- **Latency:** transfer in cycle T → respN_valid high from cycle T+2.
- **Throughput:** with resp_ready tied high, 3 cycles per operation. The next transfer can occur at T+3.
- **Alternation:** both ports continuously valid → grants alternate 0,1,0,1… when RR_INIT = 0.
- **Reset mid-operation:** rst in EXEC or RESP returns to IDLE next cycle. The in-flight operation is dropped with no response, and the pointer reloads RR_INIT.
- **Response handshake:** resp_valid is held until resp_ready is sampled high. resp_valid then drops in the following cycle, which is also the first cycle a new grant is possible.

## Test plan
- **Reset:** assert rst for 2 cycles with both valid high → after release, resp_o = 0, alu_sel = 111, no resp_valid. In the first IDLE cycle, req0_ready = 1 (RR_INIT = 0).
- **Single ADD:** port 0 sends a = 5, b = 7, sel = 000 at T; resp_ready tied 1 → resp0_valid at T+2, resp_o = 12, resp_z = 1; resp1_valid never set.
- **Contention:** both ports valid continuously with SUB 10−10 (port 0) and SRAI 0x80000000>>4 (port 1) → grants alternate 0,1,0,1. Port 0 returns resp_o = 0, resp_z = 0; port 1 returns resp_o = 0xF8000000, resp_z = 1; one operation per 3 cycles.
- **Backpressure:** port 1 sends XOR 0xFF^0x0F with resp1_ready low for 5 cycles → resp1_valid and resp_o = 0xF0 held constant; port 0 valid stays un-readied until 1 cycle after resp1_ready rises.
- **Reset in EXEC:** port 0 sends SLLI 1<<31, then rst is asserted in the EXEC cycle → no resp0_valid ever; state IDLE; resp_o = 0.
- **Invalid selector:** port 1 sends sel = 111 with a = 3, b = 4 → resp_o = 0, resp_z = 0, delivered normally at T+2.
